// File: rtl/param_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : param_fifo
//  Purpose  : Parametrised single-clock FIFO with programmable almost-full /
//             almost-empty thresholds, synchronous flush and per-cycle
//             registered ack/err handshake pulses.
//  Revision : 1.0 - initial parametrised release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock, all state updates on rising edge
//    reset        in   synchronous active-high reset
//    clear        in   synchronous flush (pointers/count only, storage kept)
//    wr_en        in   write request
//    d_in         in   write data [DATA_WIDTH]
//    rd_en        in   read request
//    d_out        out  registered read data [DATA_WIDTH]
//    full         out  data_count == DEPTH
//    empty        out  data_count == 0
//    almost_full  out  data_count >= AF_LEVEL
//    almost_empty out  data_count <= AE_LEVEL
//    wr_ack       out  previous-cycle write accepted
//    wr_err       out  previous-cycle write rejected
//    rd_ack       out  previous-cycle read accepted, d_out valid
//    rd_err       out  previous-cycle read rejected
//    data_count   out  occupancy 0..DEPTH [ADDR_WIDTH+1]
// ============================================================================
module param_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [ADDR_WIDTH:0]   data_count
);

    localparam int                 c_DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_DEPTH_CNT = (ADDR_WIDTH + 1)'(c_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_AF_CNT    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] c_AE_CNT    = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem_q [c_DEPTH];
    logic [ADDR_WIDTH-1:0] r_head_q;
    logic [ADDR_WIDTH-1:0] r_tail_q;
    logic [ADDR_WIDTH:0]   r_count_q;
    logic [DATA_WIDTH-1:0] r_dout_q;
    logic                  r_wr_ack_q;
    logic                  r_wr_err_q;
    logic                  r_rd_ack_q;
    logic                  r_rd_err_q;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic [ADDR_WIDTH:0]   w_count_d;

    assign w_full  = (r_count_q == c_DEPTH_CNT);
    assign w_empty = (r_count_q == '0);

    // A read in the same cycle frees the slot a write into a full FIFO
    // fills; an empty FIFO never forwards write data to the read side.
    assign w_wr_ok = wr_en && (!w_full || rd_en);
    assign w_rd_ok = rd_en && !w_empty;

    always_comb begin
        w_count_d = r_count_q;
        if (w_wr_ok && !w_rd_ok) begin
            w_count_d = r_count_q + 1'b1;
        end else if (w_rd_ok && !w_wr_ok) begin
            w_count_d = r_count_q - 1'b1;
        end
    end

    // Storage has no reset and is not touched by clear.
    always_ff @(posedge clk) begin
        if (!reset && !clear && w_wr_ok) begin
            r_mem_q[r_tail_q] <= d_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head_q   <= '0;
            r_tail_q   <= '0;
            r_count_q  <= '0;
            r_dout_q   <= '0;
            r_wr_ack_q <= 1'b0;
            r_wr_err_q <= 1'b0;
            r_rd_ack_q <= 1'b0;
            r_rd_err_q <= 1'b0;
        end else if (clear) begin
            // d_out intentionally holds its last value across a flush.
            r_head_q   <= '0;
            r_tail_q   <= '0;
            r_count_q  <= '0;
            r_wr_ack_q <= 1'b0;
            r_wr_err_q <= 1'b0;
            r_rd_ack_q <= 1'b0;
            r_rd_err_q <= 1'b0;
        end else begin
            r_count_q  <= w_count_d;
            r_wr_ack_q <= w_wr_ok;
            r_wr_err_q <= wr_en && !w_wr_ok;
            r_rd_ack_q <= w_rd_ok;
            r_rd_err_q <= rd_en && !w_rd_ok;
            if (w_wr_ok) begin
                r_tail_q <= r_tail_q + 1'b1;
            end
            if (w_rd_ok) begin
                // Reads the pre-edge contents, so a simultaneous write to the
                // same slot when full does not disturb the outgoing word.
                r_dout_q <= r_mem_q[r_head_q];
                r_head_q <= r_head_q + 1'b1;
            end
        end
    end

    assign d_out        = r_dout_q;
    assign data_count   = r_count_q;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count_q >= c_AF_CNT);
    assign almost_empty = (r_count_q <= c_AE_CNT);
    assign wr_ack       = r_wr_ack_q;
    assign wr_err       = r_wr_err_q;
    assign rd_ack       = r_rd_ack_q;
    assign rd_err       = r_rd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_param_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_fifo
//  Purpose  : Self-checking bench for param_fifo (32-bit, depth 8) using a
//             queue-based reference model of the FIFO behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_param_fifo;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AFL   = DEPTH - 1;
    localparam int AEL   = 1;

    logic          clk = 1'b0;
    logic          reset, clear, wr_en, rd_en;
    logic [DW-1:0] d_in;
    logic [DW-1:0] d_out;
    logic          full, empty, almost_full, almost_empty;
    logic          wr_ack, wr_err, rd_ack, rd_err;
    logic [AW:0]   data_count;

    always #5 clk = ~clk;

    param_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .AF_LEVEL   (AFL),
        .AE_LEVEL   (AEL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .wr_en        (wr_en),
        .d_in         (d_in),
        .rd_en        (rd_en),
        .d_out        (d_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .wr_ack       (wr_ack),
        .wr_err       (wr_err),
        .rd_ack       (rd_ack),
        .rd_err       (rd_err),
        .data_count   (data_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_dout;
    logic          m_wa, m_we, m_ra, m_re;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rs, input logic cl, input logic wr,
                              input logic rd, input logic [DW-1:0] d);
        int  sz;
        bit  wok, rok;
        sz = m_q.size();
        if (rs) begin
            m_q.delete();
            m_dout = '0;
            {m_wa, m_we, m_ra, m_re} = 4'b0000;
        end else if (cl) begin
            m_q.delete();
            {m_wa, m_we, m_ra, m_re} = 4'b0000;
        end else begin
            wok  = wr && ((sz < DEPTH) || rd);
            rok  = rd && (sz > 0);
            m_wa = wok;
            m_we = wr && !wok;
            m_ra = rok;
            m_re = rd && !rok;
            if (rok) m_dout = m_q.pop_front();
            if (wok) m_q.push_back(d);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = m_q.size();
        chk({tag, ".count"}, 64'(data_count),   64'(sz));
        chk({tag, ".full"},  64'(full),         64'(sz == DEPTH));
        chk({tag, ".empty"}, 64'(empty),        64'(sz == 0));
        chk({tag, ".af"},    64'(almost_full),  64'(sz >= AFL));
        chk({tag, ".ae"},    64'(almost_empty), 64'(sz <= AEL));
        chk({tag, ".dout"},  64'(d_out),        64'(m_dout));
        chk({tag, ".wack"},  64'(wr_ack),       64'(m_wa));
        chk({tag, ".werr"},  64'(wr_err),       64'(m_we));
        chk({tag, ".rack"},  64'(rd_ack),       64'(m_ra));
        chk({tag, ".rerr"},  64'(rd_err),       64'(m_re));
    endtask

    task automatic step(input string tag, input logic rs, input logic cl,
                        input logic wr, input logic rd, input logic [DW-1:0] d);
        reset = rs;
        clear = cl;
        wr_en = wr;
        rd_en = rd;
        d_in  = d;
        @(posedge clk);
        model_edge(rs, cl, wr, rd, d);
        #1;
        check_all(tag);
        reset = 1'b0;
        clear = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] v;
        int            r;
        bit            wr_bias;
        reset = 1'b1; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; d_in = '0;
        m_dout = '0;
        {m_wa, m_we, m_ra, m_re} = 4'b0000;

        // Reset then idle
        step("reset", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        step("idle",  1'b0, 1'b0, 1'b0, 1'b0, '0);
        // Direct constant checks of reset values
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_dout",  64'(d_out), 64'd0);

        // Fill 0x11..0x88 then overflow
        for (int i = 1; i <= DEPTH; i++) begin
            v = DW'(i * 32'h11);
            step("fill", 1'b0, 1'b0, 1'b1, 1'b0, v);
        end
        chk("fill_full", 64'(full), 64'd1);
        step("overflow", 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        chk("ovf_err", 64'(wr_err), 64'd1);

        // Drain and underflow
        for (int i = 1; i <= DEPTH; i++) begin
            step("drain", 1'b0, 1'b0, 1'b0, 1'b1, '0);
            chk("drain_val", 64'(d_out), 64'(i * 32'h11));
        end
        step("underflow", 1'b0, 1'b0, 1'b0, 1'b1, '0);
        chk("udf_hold", 64'(d_out), 64'h88);

        // Wrap-around: write 5, read 5, write 8, read 8
        for (int i = 0; i < 5; i++) step("wrap_w5", 1'b0, 1'b0, 1'b1, 1'b0, DW'($urandom));
        for (int i = 0; i < 5; i++) step("wrap_r5", 1'b0, 1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 8; i++) step("wrap_w8", 1'b0, 1'b0, 1'b1, 1'b0, DW'($urandom));
        // Simultaneous read+write at full, 0xAA must come out last
        step("full_rw", 1'b0, 1'b0, 1'b1, 1'b1, 32'hAA);
        chk("full_rw_cnt", 64'(data_count), 64'd8);
        for (int i = 0; i < 8; i++) step("wrap_r8", 1'b0, 1'b0, 1'b0, 1'b1, '0);
        chk("last_aa", 64'(d_out), 64'hAA);

        // Simultaneous read+write at empty
        step("empty_rw", 1'b0, 1'b0, 1'b1, 1'b1, 32'h55);
        chk("empty_rw_cnt", 64'(data_count), 64'd1);

        // Clear with count 4 and wr_en high
        for (int i = 0; i < 3; i++) step("pre_clr", 1'b0, 1'b0, 1'b1, 1'b0, DW'($urandom));
        step("clear", 1'b0, 1'b1, 1'b1, 1'b1, 32'h1234_5678);
        step("post_clr_idle", 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Reset during reads
        for (int i = 0; i < 4; i++) step("pre_rst", 1'b0, 1'b0, 1'b1, 1'b0, DW'($urandom));
        step("rd_a", 1'b0, 1'b0, 1'b0, 1'b1, '0);
        step("rst_rd", 1'b1, 1'b0, 1'b0, 1'b1, '0);
        step("rst_after", 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Randomised traffic with phases biased towards full and towards empty
        for (int i = 0; i < 400; i++) begin
            wr_bias = ((i / 40) % 2) == 0;
            r = $urandom_range(0, 199);
            step("rand",
                 r == 199,
                 r < 3,
                 ($urandom_range(0, 99) < (wr_bias ? 75 : 30)),
                 ($urandom_range(0, 99) < (wr_bias ? 30 : 75)),
                 DW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
